led_rr_arbiter: RTL and testbench
=================================

// Module: led_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8-slot display/service resource among 8 requesters.
//  At board top: req is driven from sw[7:0], done from a debounced btn[0], and ledr drives the LED bank.
//  Grants one requester at a time and holds the grant until release.
//  Rotates priority so no requester starves; replaces fixed high-index-wins priority encoding.
// PARAMETERS
//  N         8      number of requesters (fixed 8; IDXW must equal clog2(N))
//  IDXW      3      grant index width
//  MAX_HOLD  1024   max cycles a grant may be held (used only with ARB_TIMEOUT_EN); must be >=2
// PORTS
//  clk          in   1     system clock, all state on posedge
//  rst          in   1     asynchronous active-low reset (0 = reset)
//  req          in   N     request lines, level-sensitive, one per requester
//  done         in   1     release strobe from current grantee, sampled each cycle in GRANT
//  grant        out  N     one-hot grant, all-zero when idle
//  grant_valid  out  1     1 while a grant is held
//  grant_idx    out  IDXW  index of current grantee; 0 when idle
//  ledr         out  16    status: [7:0]=grant, [10:8]=grant_idx, [11]=grant_valid,
//                          [14:12]=ptr, [15]=timeout sticky flag
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, ptr=0, grant=0, grant_valid=0, grant_idx=0,
//    hold_cnt=0, timeout flag=0, ledr=16'h0000. Reset mid-grant drops grant immediately.
//  All outputs are registered; no combinational path from req/done to any output.
//  FSM states: IDLE, GRANT.
//  IDLE: at posedge, if |req, choose the winner as the first set req[k], searching
//    k = ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N). Then:
//    - grant <= onehot(k), grant_idx <= k, grant_valid <= 1, hold_cnt <= 0, go to GRANT.
//    If req == 0, stay in IDLE with outputs at their idle values.
//  Latency: req rising before edge E yields grant visible after E (1 cycle).
//  GRANT: a release occurs at posedge if done==1 OR req[grant_idx]==0. On release:
//    - grant <= 0, grant_valid <= 0, grant_idx <= 0, go to IDLE;
//    - ptr <= grant_idx+1 (mod N; 7 wraps to 0).
//    Otherwise hold: outputs unchanged and hold_cnt increments.
//  Releases cost one IDLE cycle, so back-to-back grants are spaced 1 cycle apart.
//  done is ignored in IDLE. Other reqs changing during GRANT do not affect the grant.
//  A simultaneous release and pending request is served in the following IDLE cycle,
//    using the updated ptr.
//  Single requester: it is re-granted after the 1-cycle IDLE gap, whatever the ptr value.
//  ptr changes only on release (or on timeout when enabled).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: in GRANT, when hold_cnt == MAX_HOLD-1 and there is no
//    release, the next edge forces a release:
//    - same updates as a normal release;
//    - ledr[15] set sticky until reset.
//    hold_cnt is IDXW-independent, clog2(MAX_HOLD) bits wide, and saturates; it never wraps.
//  ARB_TIMEOUT_EN undefined: no hold counter; a grant lasts until done or req drop;
//    ledr[15] is tied to 0.
// TESTING
//  1 reset: rst=0 with req=8'hFF -> grant=0, ledr=16'h0000. Release rst -> next edge
//    grant=8'h01, grant_idx=0.
//  2 rotation: req=8'hFF held, done pulsed every 3rd cycle -> grant_idx sequence
//    0,1,2,...,7,0, each followed by a 1-cycle idle gap; ledr[14:12] tracks ptr.
//  3 wrap/skip: ptr=6, req=8'b0000_0101 -> grant_idx=0; after release ptr=1 -> next
//    grant_idx=2.
//  4 req drop: granted idx 3, deassert req[3] with done=0 -> grant cleared next edge, ptr=4.
//  5 async reset mid-grant: rst=0 between edges while grant=8'h10 -> grant=0 immediately,
//    ptr=0 after release.
//  6 timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held, done=0 -> idx0 is held
//    exactly 4 cycles, then idx1; ledr[15]=1 and stays set.
//    Without the macro -> idx0 is held indefinitely and ledr[15]=0.

Source files
------------

// File: rtl/led_rr_arbiter.sv
// rtl/led_rr_arbiter.sv - round-robin arbiter for 8 requesters with LED status (optional ARB_TIMEOUT_EN hold timeout)
module led_rr_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic [15:0]     ledr
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            grant_valid_q, grant_valid_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic            to_flag_q, to_flag_d;

  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW-1:0] cand;
  logic            user_release;
  logic            force_release;

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
`else
  logic [31:0] unused_max_hold;
  assign unused_max_hold = 32'(MAX_HOLD);
`endif

  // Rotating search starting at ptr; ptr+i wraps mod N because N == 2**IDXW.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_q + IDXW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Release conditions for the current grantee: explicit done, request drop, or hold timeout.
  always_comb begin
    user_release  = done || !req[grant_idx_q];
`ifdef ARB_TIMEOUT_EN
    force_release = !user_release && (hold_cnt_q == HOLD_LAST);
`else
    force_release = 1'b0;
`endif
  end

  // Next-state and registered-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    to_flag_d     = to_flag_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d    = hold_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d       = S_GRANT;
          grant_d       = N'(1) << win_idx;
          grant_idx_d   = win_idx;
          grant_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d    = '0;
`endif
        end
      end
      S_GRANT: begin
        if (user_release || force_release) begin
          state_d       = S_IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_idx_d   = '0;
          ptr_d         = grant_idx_q + IDXW'(1);
          if (force_release) to_flag_d = 1'b1;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + HCW'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; asynchronous reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      to_flag_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      to_flag_q     <= to_flag_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Saturating hold counter for the current grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt_q <= '0;
    else      hold_cnt_q <= hold_cnt_d;
  end
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign ledr        = {to_flag_q, ptr_q, grant_valid_q, grant_idx_q, grant_q};

endmodule

// File: tb/tb_led_rr_arbiter.sv
// tb/tb_led_rr_arbiter.sv - scoreboard testbench for led_rr_arbiter
module tb_led_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic [15:0] ledr;

  always #5 clk = ~clk;

  led_rr_arbiter #(.N(8), .IDXW(3), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .ledr(ledr)
  );

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] ptr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input int idx, input int ptr);
    exp_t e;
    e.idx = 3'(idx);
    e.ptr = 3'(ptr);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every new grant is matched against the next expected grant.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (grant_valid && !prev_v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got idx %0d expected no grant", grant_idx);
      end else begin
        e = sb.pop_front();
        chk("grant_idx", 32'(grant_idx), 32'(e.idx));
        chk("grant_onehot", 32'(grant), 32'(8'h01 << e.idx));
        chk("ledr_grant", 32'(ledr[7:0]), 32'(8'h01 << e.idx));
        chk("ledr_idx", 32'(ledr[10:8]), 32'(e.idx));
        chk("ledr_valid", 32'(ledr[11]), 32'd1);
        chk("ledr_ptr", 32'(ledr[14:12]), 32'(e.ptr));
      end
    end
    prev_v = grant_valid;
  end

  task automatic wait_grant(input string name);
    int n = 0;
    while (!grant_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!grant_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no grant expected grant within 20 cycles", name);
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    rst  = 1'b0;
    req  = 8'hFF;
    done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_valid", 32'(grant_valid), 32'h0);
    chk("rst_ledr", 32'(ledr), 32'h0);

    // Reset release: first grant one edge later, index 0.
    sb.push_back(mk(0, 0));
    rst = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'h01);

    // Rotation 1..7,0 with all requesters active.
    for (int k = 1; k <= 8; k++) begin
      sb.push_back(mk(k % 8, k % 8));
      @(negedge clk);
      pulse_done();
      chk("idle_gap", 32'(grant_valid), 32'h0);
      chk("ptr_track", 32'(ledr[14:12]), 32'(k % 8));
      wait_grant("rotation");
    end

    // Release idx0 with requests gone: ptr=1.
    req = 8'h00;
    pulse_done();
    chk("ptr_after_rot", 32'(ledr[14:12]), 32'd1);

    // Move ptr to 6 via a grant to idx5.
    sb.push_back(mk(5, 1));
    req = 8'h20;
    wait_grant("to_ptr6");
    req = 8'h00;
    @(negedge clk);
    chk("ptr6", 32'(ledr[14:12]), 32'd6);

    // Wrap/skip: ptr=6, req=0000_0101 -> idx0 then idx2.
    sb.push_back(mk(0, 6));
    sb.push_back(mk(2, 1));
    req = 8'h05;
    wait_grant("wrap");
    pulse_done();
    chk("wrap_gap", 32'(grant_valid), 32'h0);
    chk("wrap_ptr", 32'(ledr[14:12]), 32'd1);
    wait_grant("skip");
    req = 8'h00;
    @(negedge clk);
    chk("skip_ptr", 32'(ledr[14:12]), 32'd3);

    // Request drop releases without done.
    sb.push_back(mk(3, 3));
    req = 8'h08;
    wait_grant("drop");
    repeat (2) @(negedge clk);
    chk("drop_held", 32'(grant), 32'h08);
    req = 8'h00;
    @(negedge clk);
    chk("drop_grant", 32'(grant), 32'h0);
    chk("drop_ptr", 32'(ledr[14:12]), 32'd4);

    // Asynchronous reset in the middle of a grant.
    sb.push_back(mk(4, 4));
    req = 8'h10;
    wait_grant("async");
    chk("pre_rst_grant", 32'(grant), 32'h10);
    #2 rst = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_ledr", 32'(ledr), 32'h0);
    @(negedge clk);
    req = 8'h00;
    rst = 1'b1;
    @(negedge clk);
    chk("async_ptr", 32'(ledr[14:12]), 32'd0);

    // Single requester is re-granted after one idle cycle; ptr wraps 7->0.
    sb.push_back(mk(7, 0));
    sb.push_back(mk(7, 0));
    req = 8'h80;
    wait_grant("single1");
    pulse_done();
    chk("single_gap", 32'(grant_valid), 32'h0);
    wait_grant("single2");
    req = 8'h00;
    @(negedge clk);
    chk("single_ptr", 32'(ledr[14:12]), 32'd0);

    // Hold timeout behaviour with req=8'h03 and done low.
    sb.push_back(mk(0, 0));
`ifdef ARB_TIMEOUT_EN
    sb.push_back(mk(1, 1));
`endif
    req = 8'h03;
    wait_grant("hold");
    n = 0;
    while (grant == 8'h01 && n < 40) begin
      n++;
      @(negedge clk);
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold_len", 32'(n), 32'd4);
    chk("to_flag", 32'(ledr[15]), 32'd1);
    wait_grant("after_timeout");
    req = 8'h00;
    repeat (2) @(negedge clk);
    chk("to_flag_sticky", 32'(ledr[15]), 32'd1);
`else
    chk("hold_indef", 32'(n), 32'd40);
    chk("no_to_flag", 32'(ledr[15]), 32'd0);
    req = 8'h00;
    repeat (2) @(negedge clk);
`endif
    chk("final_idle", 32'(grant_valid), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
